// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner:
// segment patterns {g,f,e,d,c,b,a} for 0..9, A..F, blank, and anode helpers.
package seg_display_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-low anode bit for position k: low only when the digit is
  // shown and k is the selected index; idle (1) otherwise.
  function automatic logic anode_bit(
    input logic [2:0]  sel,
    input logic        show,
    input int unsigned k
  );
    return !(show && (sel == 3'(k)));
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Load port of the display scanner: valid/ready handshake carrying
// BCD digits (4 bits each), per-digit blink enables and decimal points.
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    valid;
  logic                    ready;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink;
  logic [NUM_DIGITS-1:0]   dp;

  modport master (
    output valid, digits, blink, dp,
    input  ready
  );

  modport slave (
    input  valid, digits, blink, dp,
    output ready
  );
endinterface

// File: rtl/seg_decoder.sv
// 4-bit value to 7-segment {g,f,e,d,c,b,a} decoder, combinational.
// Ports: val_i value in, seg_o segments out. SEG_HEX_EN shows A..F for 10..15.
module seg_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
`ifdef SEG_HEX_EN
      4'd10:   seg_o = SEG_A;
      4'd11:   seg_o = SEG_B;
      4'd12:   seg_o = SEG_C;
      4'd13:   seg_o = SEG_D;
      4'd14:   seg_o = SEG_E;
      4'd15:   seg_o = SEG_F;
`else
      // 10..15 act as a digit-off code
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// N-digit multiplexed 7-segment scanner with frame-aligned content load,
// per-digit blink/dp and enable. Optional macro: SEG_HEX_EN (A..F glyphs).
// Ports: clk_osc, resetn (sync, active-low), enable, load (slave if),
// anode (active-low), seg {g..a}, dp, frame_start (pulse after wrap).
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV_W  = 16,
  parameter int BLINK_DIV_W = 24
) (
  input  logic                  clk_osc,
  input  logic                  resetn,
  input  logic                  enable,
  seg_display_scanner_if.slave  load,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_n
    $error("NUM_DIGITS out of range 2..8");
  end
  if (BLINK_DIV_W <= SCAN_DIV_W) begin : g_bad_div
    $error("BLINK_DIV_W must exceed SCAN_DIV_W");
  end

  logic [SCAN_DIV_W-1:0]   scan_cnt_q;
  logic [BLINK_DIV_W-1:0]  blink_cnt_q;
  logic [BLINK_DIV_W-1:0]  blink_cnt_d;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;

  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_blk_q, sh_blk_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q,  sh_dp_d;
  logic [4*NUM_DIGITS-1:0] pd_dig_q, pd_dig_d;
  logic [NUM_DIGITS-1:0]   pd_blk_q, pd_blk_d;
  logic [NUM_DIGITS-1:0]   pd_dp_q,  pd_dp_d;
  logic                    pend_full_q, pend_full_d;

  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q;

  logic                    scan_tick;
  logic                    boundary;
  logic                    xfer;
  logic [3:0]              cur_val;
  logic                    cur_blk;
  logic                    show;

  assign scan_tick   = &scan_cnt_q;
  assign boundary    = scan_tick && (idx_q == LAST);
  assign idx_d       = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
  assign blink_cnt_d = blink_cnt_q + BLINK_DIV_W'(1);
  assign xfer        = load.valid && !pend_full_q;
  assign load.ready  = !pend_full_q;

  // Content only ever reaches the shown set on a boundary tick, so a
  // frame always shows one consistent set of digits.
  always_comb begin
    sh_dig_d    = sh_dig_q;
    sh_blk_d    = sh_blk_q;
    sh_dp_d     = sh_dp_q;
    pd_dig_d    = pd_dig_q;
    pd_blk_d    = pd_blk_q;
    pd_dp_d     = pd_dp_q;
    pend_full_d = pend_full_q;
    if (boundary) begin
      if (pend_full_q) begin
        sh_dig_d    = pd_dig_q;
        sh_blk_d    = pd_blk_q;
        sh_dp_d     = pd_dp_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        sh_dig_d = load.digits;
        sh_blk_d = load.blink;
        sh_dp_d  = load.dp;
      end
    end else if (xfer) begin
      pd_dig_d    = load.digits;
      pd_blk_d    = load.blink;
      pd_dp_d     = load.dp;
      pend_full_d = 1'b1;
    end
  end

  // Select from next-state shown content so a commit on the boundary
  // tick is already visible in digit 0's slot.
  always_comb begin
    cur_val = '0;
    cur_blk = 1'b0;
    dp_d    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        cur_val = sh_dig_d[4*k +: 4];
        cur_blk = sh_blk_d[k];
        dp_d    = sh_dp_d[k];
      end
    end
  end

  // Phase taken from the next blink count so the window lines up with
  // the slot that starts on this tick.
  assign show = enable && !(blink_cnt_d[BLINK_DIV_W-1] && cur_blk);

  always_comb begin
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      anode_d[k] = anode_bit(3'(idx_d), show, k);
    end
  end

  seg_decoder u_dec (
    .val_i (cur_val),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk_osc) begin
    if (!resetn) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      idx_q         <= '0;
      sh_dig_q      <= '0;
      sh_blk_q      <= '0;
      sh_dp_q       <= '0;
      pd_dig_q      <= '0;
      pd_blk_q      <= '0;
      pd_dp_q       <= '0;
      pend_full_q   <= 1'b0;
      anode_q       <= '1;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_q + SCAN_DIV_W'(1);
      blink_cnt_q   <= blink_cnt_d;
      sh_dig_q      <= sh_dig_d;
      sh_blk_q      <= sh_blk_d;
      sh_dp_q       <= sh_dp_d;
      pd_dig_q      <= pd_dig_d;
      pd_blk_q      <= pd_blk_d;
      pd_dp_q       <= pd_dp_d;
      pend_full_q   <= pend_full_d;
      frame_start_q <= boundary;
      if (scan_tick) begin
        idx_q   <= idx_d;
        anode_q <= anode_d;
        seg_q   <= seg_d;
        dp_q    <= dp_d;
      end
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with NUM_DIGITS=4,
// SCAN_DIV_W=2, BLINK_DIV_W=6; outputs sampled on the falling edge.
module tb_seg_display_scanner;

  logic       clk_osc = 1'b0;
  logic       resetn;
  logic       enable;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] blink_exp [0:16];
  logic [3:0] frm_an    [0:6];
  logic [6:0] frm_seg   [0:6];
  logic [6:0] exp_a;

  always #5 clk_osc = ~clk_osc;

  seg_display_scanner_if #(.NUM_DIGITS(4)) lif ();

  seg_display_scanner #(
    .NUM_DIGITS  (4),
    .SCAN_DIV_W  (2),
    .BLINK_DIV_W (6)
  ) dut (
    .clk_osc     (clk_osc),
    .resetn      (resetn),
    .enable      (enable),
    .load        (lif),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_osc);
      @(negedge clk_osc);
    end
  endtask

  task automatic offer(
    input logic [15:0] d,
    input logic [3:0]  b,
    input logic [3:0]  p
  );
    lif.valid  = 1'b1;
    lif.digits = d;
    lif.blink  = b;
    lif.dp     = p;
    step(1);
    lif.valid  = 1'b0;
  endtask

  initial begin
`ifdef SEG_HEX_EN
    exp_a = 7'b1110111;
`else
    exp_a = 7'b0000000;
`endif
    blink_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                  4'b1110, 4'b1101, 4'b1011, 4'b0111,
                  4'b1111, 4'b1101, 4'b1011, 4'b0111,
                  4'b1111, 4'b1101, 4'b1011, 4'b0111,
                  4'b1110};
    frm_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                4'b1101, 4'b1011, 4'b0111};
    frm_seg = '{7'b0111111, 7'b0111111, 7'b0111111,
                7'b1100110, 7'b1001111, 7'b1011011,
                7'b0000110};

    resetn     = 1'b0;
    enable     = 1'b1;
    lif.valid  = 1'b0;
    lif.digits = '0;
    lif.blink  = '0;
    lif.dp     = '0;
    @(negedge clk_osc);
    step(2);
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_frame", 32'(frame_start), 32'h0);
    check("rst_ready", 32'(lif.ready), 32'h1);

    // Idle frame after release: E1..E3 dark, then 1101 at E4
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("idle_dark", 32'(anode), 32'hF);
    end
    step(1);
    check("idle_an1", 32'(anode), 32'hD);
    check("idle_seg1", 32'(seg), 32'h3F);
    step(4);
    check("idle_an2", 32'(anode), 32'hB);
    step(4);
    check("idle_an3", 32'(anode), 32'h7);
    check("idle_seg3", 32'(seg), 32'h3F);
    check("idle_fs0", 32'(frame_start), 32'h0);
    step(4);
    check("idle_an0", 32'(anode), 32'hE);
    check("idle_seg0", 32'(seg), 32'h3F);
    check("idle_fs1", 32'(frame_start), 32'h1);

    // Mid-frame load at E17, committed at E32
    offer(16'h1234, 4'b0000, 4'b0000);
    check("pend_fs_low", 32'(frame_start), 32'h0);
    check("pend_ready", 32'(lif.ready), 32'h0);
    step(3);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(4);
      check("ld_anode", 32'(anode), 32'(frm_an[i]));
      check("ld_seg", 32'(seg), 32'(frm_seg[i]));
      check("ld_ready", 32'(lif.ready), (i < 3) ? 32'h0 : 32'h1);
      check("ld_fs", 32'(frame_start), (i == 3) ? 32'h1 : 32'h0);
    end

    // Bypass: offer on the boundary-tick cycle (E48)
    step(3);
    check("byp_pre_an", 32'(anode), 32'h7);
    offer(16'h5678, 4'b0000, 4'b0000);
    check("byp_anode", 32'(anode), 32'hE);
    check("byp_seg", 32'(seg), 32'h7F);
    check("byp_ready", 32'(lif.ready), 32'h1);
    check("byp_fs", 32'(frame_start), 32'h1);

    // Blink digit 0, dp on digit 1; committed at E64
    offer(16'h5555, 4'b0001, 4'b0010);
    check("blk_ready0", 32'(lif.ready), 32'h0);
    step(15);
    check("blk_ready1", 32'(lif.ready), 32'h1);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step(4);
      check("blk_anode", 32'(anode), 32'(blink_exp[i]));
      check("blk_seg", 32'(seg), 32'h6D);
      check("blk_dp", 32'(dp), (i % 4 == 1) ? 32'h1 : 32'h0);
    end

    // Value 4'hA, committed at E144
    offer(16'h000A, 4'b0000, 4'b0000);
    step(15);
    check("hex_anode", 32'(anode), 32'hE);
    check("hex_seg", 32'(seg), 32'(exp_a));

    // Enable drop takes effect at the next tick only
    enable = 1'b0;
    step(3);
    check("en_hold", 32'(anode), 32'hE);
    step(1);
    check("en_off", 32'(anode), 32'hF);
    check("en_seg", 32'(seg), 32'h3F);
    enable = 1'b1;
    step(4);
    check("en_back", 32'(anode), 32'hB);

    // Reset mid-frame with content pending
    offer(16'h8888, 4'b1111, 4'b1111);
    check("mrst_pend", 32'(lif.ready), 32'h0);
    resetn = 1'b0;
    step(1);
    check("mrst_anode", 32'(anode), 32'hF);
    check("mrst_seg", 32'(seg), 32'h0);
    check("mrst_dp", 32'(dp), 32'h0);
    check("mrst_fs", 32'(frame_start), 32'h0);
    check("mrst_ready", 32'(lif.ready), 32'h1);
    resetn = 1'b1;
    step(4);
    check("post_an1", 32'(anode), 32'hD);
    check("post_seg1", 32'(seg), 32'h3F);
    step(12);
    check("post_an0", 32'(anode), 32'hE);
    check("post_seg0", 32'(seg), 32'h3F);
    check("post_dp0", 32'(dp), 32'h0);
    check("post_fs", 32'(frame_start), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Parametrised, multiplexed N-digit 7-segment display driver for the board's clock/alarm/stopwatch user interface. It replaces the fixed 4-digit scan logic in the top level with a block that has a configurable digit count, scan rate and blink rate. It also adds per-digit blink and decimal-point control, an enable, and a valid/ready load port whose data is committed only at frame boundaries, so digits never tear mid-frame. It sits between the service modules, which produce BCD digits, and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- SCAN_DIV_W, 16: scan divider width; one digit step every 2^SCAN_DIV_W clk_osc cycles.
- BLINK_DIV_W, 24: blink divider width; the blink phase toggles every 2^(BLINK_DIV_W-1) cycles. Must exceed SCAN_DIV_W.
- clk_osc  in  1  board oscillator clock.
- resetn  in  1  reset, synchronous, active-low; clock clk_osc.
- enable  in  1  0 forces all anodes off; counters keep running.
- load_valid  in  1  new display content offered.
- load_ready  out  1  block can accept content.
- load_digits  in  4*NUM_DIGITS  digit k is bits [4k+3:4k]; digit 0 is the rightmost.
- load_blink  in  NUM_DIGITS  per-digit blink enable.
- load_dp  in  NUM_DIGITS  per-digit decimal point.
- anode  out  NUM_DIGITS  active-low digit select; at most one bit is low.
- seg  out  7  {g,f,e,d,c,b,a}, active-high.
- dp  out  1  decimal point, active-high.
- frame_start  out  1  one-cycle pulse when the scan index wraps to digit 0.

## Operation
- scan_cnt (SCAN_DIV_W bits) is free-running. scan_tick is asserted when scan_cnt is all ones.
- On scan_tick, idx advances: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - anode, seg and dp are registered in the same cycle from the new idx.
  - A boundary tick is one where idx wraps to 0. frame_start = 1 on the cycle following a boundary tick.
- Shown registers: digits, blink, dp. Pending registers hold the same fields plus a pend_full flag.
- Handshake:
  - load_ready = !pend_full.
  - Transfer occurs when load_valid && load_ready.
  - A transfer on a non-boundary cycle loads the pending registers and sets pend_full.
  - A transfer on a boundary-tick cycle bypasses pending and writes the shown registers directly.
  - On a boundary tick with pend_full set, pending is copied to shown and pend_full is cleared.
  - load_valid may drop without a transfer; no ordering obligation applies.
- Blink: blink_cnt (BLINK_DIV_W bits) is free-running, and phase is its MSB. When phase = 1 and blink[idx] = 1, anode is all ones for that slot. seg and dp are still driven.
- enable = 0 forces anode to all ones. It is sampled at every scan_tick and takes effect at the next update.
- Decode values 0..9 with the standard table; for example, 0 = 0111111 and 8 = 1111111. Values 10..15 are governed by the Configuration macro.

## Timing
- Reset values:
  - anode = all ones; seg = 0000000; dp = 0; frame_start = 0.
  - idx = 0; scan_cnt = 0; blink_cnt = 0.
  - Shown registers = 0; pend_full = 0, so load_ready = 1.
- First display update occurs 2^SCAN_DIV_W cycles after reset release, showing digit 1. The first boundary tick occurs NUM_DIGITS ticks later.
- Content latency, from transfer to appearance on digit 0's anode cycle:
  - Bypass case: 1 cycle.
  - Otherwise: up to NUM_DIGITS*2^SCAN_DIV_W+1 cycles.
- load_ready falls in the cycle after a non-bypass transfer. It rises in the cycle after the committing boundary tick.
- resetn asserted mid-frame clears pending content and shown content in that cycle; no partial commit occurs.
- Outputs are registered only. Nothing is combinational from the load inputs to anode, seg or dp.

## Configuration
- SEG_HEX_EN defined: values 10..15 display A = 1110111, b = 1111100, C = 0111001, d = 1011110, E = 1111001, F = 1110001.
- SEG_HEX_EN undefined: values 10..15 display blank (0000000), which the service modules use as a digit-off code.

## Structure
- Package seg_display_pkg holds:
  - the seven-bit segment constants for 0..9, A..F and SEG_BLANK;
  - the one-hot-low anode idle constant function.
- Sub-module seg_decoder: 4-bit value in, 7-bit seg out, combinational. It holds the SEG_HEX_EN conditional and is instantiated once on the selected digit.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV_W=2, BLINK_DIV_W=6.
- Reset, then idle: anode stays 1111 and seg stays 0000000 for 4 cycles. Anode then steps 1101, 1011, 0111, 1110, with seg = 0111111 each time and frame_start pulsing after 1110.
- Load 16'h1234 mid-frame: load_ready goes 0 and digits are unchanged until the next boundary. From then on, the anode=1110 slot shows seg = 1100110 (4) and anode=0111 shows seg = 0000110 (1). load_ready returns to 1.
- Load on a boundary-tick cycle: bypass is taken, load_ready stays 1, and the new digit 0 appears in the same frame.
- blink = 0001 with digits 5555: digit 0's anode stays high for 32-cycle windows while blink_cnt MSB = 1. The other digits are unaffected. With dp = 0010, dp = 1 only in the 1101 slot.
- Digit value 4'hA: blank without SEG_HEX_EN, 1110111 with it. Drop enable: anode goes 1111 at the next tick. Assert resetn low mid-frame: all outputs return to their reset values next cycle.
